openfire_prefetch: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. Issues word requests to instruction memory through a req/ack handshake that allows wait states, and buffers returned words in a 2-entry prefetch queue. Each non-stalled cycle it presents one {pc_decode, instruction} pair to decode. Branch redirects clear the queue and discard any in-flight fetch.

---
 rtl/openfire_fetch_pkg.sv | 17 +
 rtl/openfire_prefetch_if.sv | 25 ++
 rtl/openfire_fetch_queue.sv | 74 +++++++
 rtl/openfire_prefetch.sv | 136 +++++++++++++
 tb/tb_openfire_prefetch.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/openfire_fetch_pkg.sv
// rtl/openfire_fetch_pkg.sv - shared constants and state encoding for the openfire fetch stage
package openfire_fetch_pkg;

  localparam logic [31:0] NOP = 32'h8000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Queue entry is {pc, instruction}
  function automatic int entry_w(input int a_space);
    return a_space + 2 + 32;
  endfunction

endpackage

// File: rtl/openfire_prefetch_if.sv
// rtl/openfire_prefetch_if.sv - instruction memory req/ack port
interface openfire_prefetch_if #(
  parameter int A_SPACE = 16
) ();

  logic                 imem_req;
  logic [A_SPACE+1:0]   imem_addr;
  logic                 imem_ack;
  logic [31:0]          imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/openfire_fetch_queue.sv
// rtl/openfire_fetch_queue.sv - circular prefetch FIFO, clear has priority over push
module openfire_fetch_queue #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == FULL_CNT);
    empty   = (cnt_q == '0);
    head    = mem_q[rd_q];
    do_pop  = pop && !empty && !clear;
    do_push = push && (!full || do_pop) && !clear;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_d = rd_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/openfire_prefetch.sv
// rtl/openfire_prefetch.sv - instruction prefetch stage feeding decode
// FETCH_ALIGN_CHECK_EN adds the fetch_misalign output for unaligned branch targets.
module openfire_prefetch
  import openfire_fetch_pkg::*;
#(
  parameter int                 A_SPACE  = 16,
  parameter logic [A_SPACE+1:0] RESET_PC = '0,
  parameter int                 QDEPTH   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [A_SPACE+1:0]   branch_target,
  openfire_prefetch_if.master  imem,
  output logic [A_SPACE+1:0]   pc_decode,
  output logic [31:0]          instruction,
  output logic                 instr_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                 fetch_misalign
`endif
);

  localparam int PCW = A_SPACE + 2;
  localparam int EW  = entry_w(A_SPACE);
  localparam logic [PCW-1:0] ALIGN_MASK = {{(PCW-2){1'b1}}, 2'b00};
  localparam logic [PCW-1:0] PC_STEP    = PCW'(4);

  fetch_state_e   state_q, state_d;
  logic [PCW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PCW-1:0] pc_decode_q, pc_decode_d;
  logic [31:0]    instruction_q, instruction_d;
  logic           instr_valid_q, instr_valid_d;
  logic [PCW-1:0] target;
  logic           q_push, q_pop, q_full, q_empty;
  logic           can_issue, ack_take, req;
  logic [EW-1:0]  q_head;

  openfire_fetch_queue #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (branch_taken),
    .din   ({fetch_pc_q, imem.imem_data}),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  always_comb begin
    target    = branch_target & ALIGN_MASK;
    q_pop     = !stall && !q_empty && !branch_taken;
    // A slot freed by this cycle's pop may be claimed by the new request
    can_issue = !q_full || q_pop;
    ack_take  = (state_q == WAIT) && imem.imem_ack && !branch_taken;
    q_push    = ack_take;
    req       = (state_q == FETCH) && can_issue && !branch_taken && !reset;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      FETCH:   if (req) state_d = WAIT;
      WAIT:    if (ack_take) begin
                 fetch_pc_d = fetch_pc_q + PC_STEP;
                 state_d    = FETCH;
               end
      DISCARD: if (imem.imem_ack) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (branch_taken) begin
      fetch_pc_d = target;
      state_d    = (state_q != FETCH && !imem.imem_ack) ? DISCARD : FETCH;
    end

    pc_decode_d   = pc_decode_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    if (!stall) begin
      if (branch_taken) begin
        pc_decode_d   = target;
        instruction_d = NOP;
        instr_valid_d = 1'b0;
      end else if (!q_empty) begin
        pc_decode_d   = q_head[EW-1:32];
        instruction_d = q_head[31:0];
        instr_valid_d = 1'b1;
      end else begin
        instruction_d = NOP;
        instr_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      pc_decode_q   <= RESET_PC;
      instruction_q <= NOP;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_decode_q   <= pc_decode_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc_q;
  assign pc_decode      = pc_decode_q;
  assign instruction    = instruction_q;
  assign instr_valid    = instr_valid_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_misalign_q, fetch_misalign_d;

  always_comb begin
    fetch_misalign_d = branch_taken && (branch_target[1:0] != 2'b00);
  end

  always_ff @(posedge clock) begin
    if (reset) fetch_misalign_q <= 1'b0;
    else       fetch_misalign_q <= fetch_misalign_d;
  end

  assign fetch_misalign = fetch_misalign_q;
`endif

endmodule

// File: tb/tb_openfire_prefetch.sv
// tb/tb_openfire_prefetch.sv - directed vector bench for openfire_prefetch
module tb_openfire_prefetch;
  import openfire_fetch_pkg::*;

  localparam int A_SPACE = 16;
  localparam int PCW     = A_SPACE + 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           stall = 1'b0;
  logic           branch_taken = 1'b0;
  logic [PCW-1:0] branch_target = '0;
  logic [PCW-1:0] pc_decode;
  logic [31:0]    instruction;
  logic           instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic           fetch_misalign;
`endif

  openfire_prefetch_if #(.A_SPACE(A_SPACE)) imem ();

  openfire_prefetch #(
    .A_SPACE  (A_SPACE),
    .RESET_PC ('0),
    .QDEPTH   (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .pc_decode     (pc_decode),
    .instruction   (instruction),
    .instr_valid   (instr_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: registers the request, acks after mem_delay extra cycles
  logic           pend = 1'b0;
  int             cnt = 0;
  int             mem_delay = 0;
  logic [PCW-1:0] paddr = '0;
  logic           seen_req = 1'b0;
  logic [PCW-1:0] seen_addr = '0;

  typedef struct {
    logic           st;
    logic           br;
    logic [PCW-1:0] tgt;
    int             dly;
    logic           v;
    logic [PCW-1:0] pc;
    logic           rq;
    logic [PCW-1:0] ad;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] tag(input logic [PCW-1:0] a);
    return 32'h1000_0000 | 32'(a);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic br, input logic [PCW-1:0] tgt, input int dly,
                     input logic v, input logic [PCW-1:0] pc, input logic rq, input logic [PCW-1:0] ad);
    vec_t e;
    e.st = st; e.br = br; e.tgt = tgt; e.dly = dly;
    e.v = v; e.pc = pc; e.rq = rq; e.ad = ad;
    vq.push_back(e);
  endtask

  task automatic mem_update();
    imem.imem_ack  = 1'b0;
    imem.imem_data = 32'hDEAD_BEEF;
    if (seen_req) begin
      pend  = 1'b1;
      cnt   = mem_delay;
      paddr = seen_addr;
    end
    if (pend) begin
      if (cnt == 0) begin
        imem.imem_ack  = 1'b1;
        imem.imem_data = tag(paddr);
        pend           = 1'b0;
      end else begin
        cnt--;
      end
    end
  endtask

  // Called at the negedge: capture the request, cross the edge, update memory
  task automatic finish_cycle();
    seen_req  = imem.imem_req;
    seen_addr = imem.imem_addr;
    @(posedge clock);
    #1;
    mem_update();
  endtask

  task automatic wait_valid(input string nm, input int max);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      finish_cycle();
    end
    if (!found) @(negedge clock);
    check({nm, "_timeout"}, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PCW-1:0] exp_pc;
    logic           prev_valid;
    int             nvalid;

    imem.imem_ack  = 1'b0;
    imem.imem_data = 32'h0;

    // cycle-by-cycle table from the first post-reset cycle
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h000,1'b1,18'h000); // 0
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h000,1'b0,18'h000);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h000,1'b1,18'h004);
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h000,1'b0,18'h004);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h000,1'b1,18'h008);
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h004,1'b0,18'h008); // 5
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h004,1'b1,18'h00C);
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h008,1'b0,18'h00C);
    add(1'b1,1'b0,18'h0,0,   1'b0,18'h008,1'b1,18'h010);
    add(1'b1,1'b0,18'h0,0,   1'b0,18'h008,1'b0,18'h010);
    add(1'b1,1'b0,18'h0,0,   1'b0,18'h008,1'b0,18'h014); // 10
    add(1'b1,1'b0,18'h0,0,   1'b0,18'h008,1'b0,18'h014);
    add(1'b1,1'b0,18'h0,0,   1'b0,18'h008,1'b0,18'h014);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h008,1'b1,18'h014);
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h00C,1'b0,18'h014);
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h010,1'b1,18'h018); // 15
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h014,1'b0,18'h018);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h014,1'b1,18'h01C);
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h018,1'b0,18'h01C);
    add(1'b0,1'b0,18'h0,2,   1'b0,18'h018,1'b1,18'h020);
    add(1'b0,1'b1,18'h100,2, 1'b1,18'h01C,1'b0,18'h020); // 20
    add(1'b0,1'b0,18'h0,2,   1'b0,18'h100,1'b0,18'h100);
    add(1'b0,1'b0,18'h0,2,   1'b0,18'h100,1'b0,18'h100);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h100,1'b1,18'h100);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h100,1'b0,18'h100);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h100,1'b1,18'h104); // 25
    add(1'b1,1'b1,18'h200,0, 1'b1,18'h100,1'b0,18'h104);
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h100,1'b1,18'h200);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h100,1'b0,18'h200);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h100,1'b1,18'h204);
    add(1'b0,1'b1,18'h300,0, 1'b1,18'h200,1'b0,18'h204); // 30
    add(1'b0,1'b1,18'h400,0, 1'b0,18'h300,1'b0,18'h300);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h400,1'b1,18'h400);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h400,1'b0,18'h400);
    add(1'b0,1'b0,18'h0,0,   1'b0,18'h400,1'b1,18'h404);
    add(1'b0,1'b0,18'h0,0,   1'b1,18'h400,1'b0,18'h404); // 35

    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("reset_pc",    32'(pc_decode),     32'h0);
    check("reset_instr", instruction,        NOP);
    check("reset_valid", 32'(instr_valid),   32'h0);
    check("reset_req",   32'(imem.imem_req), 32'h0);
    check("reset_addr",  32'(imem.imem_addr),32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("reset_misalign", 32'(fetch_misalign), 32'h0);
`endif
    finish_cycle();
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      stall         = vq[i].st;
      branch_taken  = vq[i].br;
      branch_target = vq[i].tgt;
      mem_delay     = vq[i].dly;
      @(negedge clock);
      check($sformatf("c%0d_valid", i), 32'(instr_valid), 32'(vq[i].v));
      check($sformatf("c%0d_pc", i),    32'(pc_decode),   32'(vq[i].pc));
      check($sformatf("c%0d_instr", i), instruction,      vq[i].v ? tag(vq[i].pc) : NOP);
      check($sformatf("c%0d_req", i),   32'(imem.imem_req),  32'(vq[i].rq));
      check($sformatf("c%0d_addr", i),  32'(imem.imem_addr), 32'(vq[i].ad));
      finish_cycle();
    end

    // Slow memory: every instruction separated by bubbles, PCs strictly sequential
    stall         = 1'b0;
    branch_taken  = 1'b0;
    mem_delay     = 3;
    exp_pc        = 18'h404;
    prev_valid    = 1'b1;
    nvalid        = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        check($sformatf("slow%0d_pc", nvalid),    32'(pc_decode), 32'(exp_pc));
        check($sformatf("slow%0d_instr", nvalid), instruction,    tag(exp_pc));
        if (nvalid > 0) check($sformatf("slow%0d_bubble", nvalid), 32'(prev_valid), 32'h0);
        exp_pc = exp_pc + 18'h4;
        nvalid++;
      end
      prev_valid = instr_valid;
      finish_cycle();
    end
    check("slow_count_ge6", 32'(nvalid >= 6), 32'h1);

    // Redirect near the top of the address space: fetch_pc wraps to zero
    mem_delay     = 0;
    branch_taken  = 1'b1;
    branch_target = 18'h3FFFC;
    @(negedge clock);
    finish_cycle();
    branch_taken  = 1'b0;
    @(negedge clock);
    check("wrap_redirect_pc",    32'(pc_decode),   32'h3FFFC);
    check("wrap_redirect_valid", 32'(instr_valid), 32'h0);
    check("wrap_redirect_instr", instruction,      NOP);
    finish_cycle();
    wait_valid("wrap_first", 20);
    check("wrap_first_pc",    32'(pc_decode), 32'h3FFFC);
    check("wrap_first_instr", instruction,    tag(18'h3FFFC));
    finish_cycle();
    wait_valid("wrap_second", 20);
    check("wrap_second_pc",    32'(pc_decode), 32'h0);
    check("wrap_second_instr", instruction,    tag(18'h0));
    finish_cycle();

    // Unaligned target: low bits dropped, optional misalign pulse
    branch_taken  = 1'b1;
    branch_target = 18'h102;
    @(negedge clock);
    finish_cycle();
    branch_taken  = 1'b0;
    @(negedge clock);
    check("align_addr",  32'(imem.imem_addr), 32'h100);
    check("align_pc",    32'(pc_decode),      32'h100);
    check("align_valid", 32'(instr_valid),    32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_pulse", 32'(fetch_misalign), 32'h1);
`endif
    finish_cycle();
    @(negedge clock);
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_clear", 32'(fetch_misalign), 32'h0);
`endif
    wait_valid("align_first", 20);
    check("align_first_pc",    32'(pc_decode), 32'h100);
    check("align_first_instr", instruction,    tag(18'h100));
    finish_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
